// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: receive-FIFO push/status bundle between the framer and the FIFO.
//   rf_push    : one-cycle push strobe (framer -> FIFO)
//   rf_data_in : pushed word {data[7:0], break, parity_err, framing_err}
//   rf_count   : FIFO fill level (FIFO -> framer)
//   rf_pop     : FIFO read strobe (FIFO -> framer)
interface uart_rx_framer_if #(
    parameter int unsigned FIFO_WIDTH     = 11,
    parameter int unsigned FIFO_COUNTER_W = 5
) ();
    logic                      rf_push;
    logic [FIFO_WIDTH-1:0]     rf_data_in;
    logic [FIFO_COUNTER_W-1:0] rf_count;
    logic                      rf_pop;

    modport master (output rf_push, output rf_data_in, input rf_count, input rf_pop);
    modport slave  (input rf_push, input rf_data_in, output rf_count, output rf_pop);
endinterface

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART serial receive front end.
// Synchronises the RX pad, validates start bits, deserialises 5-8 data bits with
// optional parity on a 16x oversampling enable, pushes one word per character and
// generates the character-timeout level.
//   clk, wb_rst_i : clock, synchronous active-high reset
//   enable        : 1/16 bit-time pulse from the baud generator
//   srx_pad_i     : asynchronous serial input (idle high)
//   lcr           : line control ([1:0] len-5, [2] 2 stop, [3] par en, [4] even, [5] stick)
//   fifo          : FIFO push/status bundle (master side)
//   rx_idle       : FSM is in IDLE
//   rx_timeout    : character-timeout level
module uart_rx_framer #(
    parameter int unsigned FIFO_WIDTH     = 11,
    parameter int unsigned FIFO_COUNTER_W = 5,
    parameter int unsigned TOC_W          = 10
) (
    input  logic                   clk,
    input  logic                   wb_rst_i,
    input  logic                   enable,
    input  logic                   srx_pad_i,
    input  logic [7:0]             lcr,
    uart_rx_framer_if.master       fifo,
    output logic                   rx_idle,
    output logic                   rx_timeout
);
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BCNT_W = 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

    state_t              state, state_next;
    logic [TICK_W-1:0]   tick, tick_next;
    logic [BCNT_W-1:0]   bit_cnt, bit_next;
    logic                srx_meta, srx_s, srx_d;
    logic [5:0]          lcr_q;
    logic [7:0]          rshift;
    logic                brk_acc, perr;
    logic [TOC_W-1:0]    toc, toc_next, toc_thr;
    logic [3:0]          len, frame_bits;
    logic [BCNT_W-1:0]   last_bit;
    logic                par_exp;
    logic                mid, bit_end;
    logic                start_ok, data_smp, par_smp, stop_smp;
    logic                unused_lcr;

    assign unused_lcr = ^lcr[7:6];
    assign last_bit   = BCNT_W'(lcr_q[1:0]) + 3'd4;
    // Stick parity forces the bit; otherwise even/odd over the received data.
    assign par_exp    = lcr_q[5] ? ~lcr_q[4] : (lcr_q[4] ? ^rshift : ~^rshift);

    // State register.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            tick    <= tick_next;
            bit_cnt <= bit_next;
        end
    end

    // Next state and sample strobes; tick is cleared on every state change.
    always_comb begin
        state_next = state;
        tick_next  = tick;
        bit_next   = bit_cnt;
        start_ok   = 1'b0;
        data_smp   = 1'b0;
        par_smp    = 1'b0;
        stop_smp   = 1'b0;
        mid        = enable && (tick == 4'd7);
        bit_end    = enable && (tick == 4'd15);
        if (enable) tick_next = tick + 4'd1;
        case (state)
            IDLE: begin
                bit_next = '0;
                if (srx_d && !srx_s) state_next = START;
            end
            START: begin
                if (mid) begin
                    if (srx_s) state_next = IDLE;
                    else       start_ok   = 1'b1;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                data_smp = mid;
                if (bit_end) begin
                    if (bit_cnt == last_bit) begin
                        bit_next   = '0;
                        state_next = lcr_q[3] ? PARITY : STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                par_smp = mid;
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                // Leave at mid-bit so the next start edge is not missed.
                if (mid) begin
                    stop_smp   = 1'b1;
                    state_next = PUSH;
                end
            end
            PUSH:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state_next != state) tick_next = '0;
    end

    // Character-timeout threshold: 64 enables (4 bit times) per frame bit.
    always_comb begin
        len        = 4'd5 + 4'(lcr[1:0]);
        frame_bits = 4'd1 + len + 4'(lcr[3]) + (lcr[2] ? 4'd2 : 4'd1);
        toc_thr    = TOC_W'({frame_bits, 6'b0});
        toc_next   = toc;
        if (fifo.rf_push || fifo.rf_pop || (fifo.rf_count == '0))
            toc_next = '0;
        else if (enable && (toc != {TOC_W{1'b1}}))
            toc_next = toc + TOC_W'(1);
    end

    // Synchroniser, frame datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            srx_meta        <= 1'b1;
            srx_s           <= 1'b1;
            srx_d           <= 1'b1;
            lcr_q           <= '0;
            rshift          <= '0;
            brk_acc         <= 1'b0;
            perr            <= 1'b0;
            fifo.rf_push    <= 1'b0;
            fifo.rf_data_in <= '0;
            rx_idle         <= 1'b1;
            toc             <= '0;
            rx_timeout      <= 1'b0;
        end else begin
            srx_meta <= srx_pad_i;
            srx_s    <= srx_meta;
            srx_d    <= srx_s;
            if (start_ok) begin
                lcr_q   <= lcr[5:0];
                rshift  <= '0;
                brk_acc <= 1'b1;
                perr    <= 1'b0;
            end
            if (data_smp) begin
                rshift[bit_cnt] <= srx_s;
                brk_acc         <= brk_acc & ~srx_s;
            end
            if (par_smp) begin
                perr    <= (srx_s != par_exp);
                brk_acc <= brk_acc & ~srx_s;
            end
            fifo.rf_push <= stop_smp;
            if (stop_smp)
                fifo.rf_data_in <= FIFO_WIDTH'({rshift, brk_acc & ~srx_s, perr, ~srx_s});
            rx_idle    <= (state_next == IDLE);
            toc        <= toc_next;
            rx_timeout <= (toc_next >= toc_thr) && (fifo.rf_count != '0);
        end
    end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed self-checking bench for uart_rx_framer.
module tb_uart_rx_framer;
    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       enable;
    logic       srx_pad_i;
    logic [7:0] lcr;
    logic       rx_idle;
    logic       rx_timeout;
    logic       en_cont;

    int n_checks = 0;
    int n_fail   = 0;
    int push_cnt = 0;
    int consec   = 0;
    logic [10:0] last_word = '0;

    uart_rx_framer_if #(.FIFO_WIDTH(11), .FIFO_COUNTER_W(5)) fifo ();

    uart_rx_framer #(.FIFO_WIDTH(11), .FIFO_COUNTER_W(5), .TOC_W(10)) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .enable     (enable),
        .srx_pad_i  (srx_pad_i),
        .lcr        (lcr),
        .fifo       (fifo.master),
        .rx_idle    (rx_idle),
        .rx_timeout (rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Baud enable: every 4th clk, or every clk when en_cont is set.
    initial begin
        int div;
        div    = 0;
        enable = 1'b0;
        forever begin
            @(negedge clk);
            if (en_cont) enable = 1'b1;
            else begin
                enable = (div == 3);
                div    = (div + 1) % 4;
            end
        end
    end

    // Push monitor sampled on the falling edge.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo.rf_push === 1'b1) begin
                push_cnt++;
                last_word = fifo.rf_data_in;
                if (prev) consec++;
            end
            prev = (fifo.rf_push === 1'b1);
        end
    end

    task automatic hold(input logic lvl, input int clks);
        srx_pad_i = lvl;
        repeat (clks) @(negedge clk);
    endtask

    // Start, nbits data LSB first, optional parity (par<0: none), one stop, then idle level.
    task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                              input logic stop, input logic after, input int bclk);
        hold(1'b0, bclk);
        for (int i = 0; i < nbits; i++) hold(d[i], bclk);
        if (par >= 0) hold(par[0], bclk);
        hold(stop, bclk);
        hold(after, bclk);
    endtask

    initial begin
        int base;
        wb_rst_i      = 1'b1;
        srx_pad_i     = 1'b1;
        lcr           = 8'h03;
        en_cont       = 1'b0;
        fifo.rf_count = '0;
        fifo.rf_pop   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_push", 32'(fifo.rf_push), 32'd0);
        check("rst_data", 32'(fifo.rf_data_in), 32'd0);
        check("rst_idle", 32'(rx_idle), 32'd1);
        check("rst_tmo", 32'(rx_timeout), 32'd0);
        wb_rst_i = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 0xA5, rx_idle low mid-frame and high after the push
        base = push_cnt;
        srx_pad_i = 1'b0;
        repeat (8) @(negedge clk);
        check("a5_busy", 32'(rx_idle), 32'd0);
        repeat (56) @(negedge clk);
        for (int i = 0; i < 8; i++) hold(8'hA5 >> i, 64);
        hold(1'b1, 128);
        check("a5_cnt", 32'(push_cnt - base), 32'd1);
        check("a5_word", 32'(last_word), 32'h528);
        check("a5_idle", 32'(rx_idle), 32'd1);

        // 7E1: bad then good parity
        lcr  = 8'h1A;
        base = push_cnt;
        send_frame(8'h35, 7, 1, 1'b1, 1'b1, 64);
        check("7e1_bad_cnt", 32'(push_cnt - base), 32'd1);
        check("7e1_bad_word", 32'(last_word), 32'h1AA);
        send_frame(8'h35, 7, 0, 1'b1, 1'b1, 64);
        check("7e1_ok_word", 32'(last_word), 32'h1A8);
        check("7e1_ok_cnt", 32'(push_cnt - base), 32'd2);

        // Framing error, line stays low afterwards without retriggering
        lcr  = 8'h03;
        base = push_cnt;
        send_frame(8'h5A, 8, -1, 1'b0, 1'b0, 64);
        hold(1'b0, 700);
        check("fe_word", 32'(last_word), 32'h2D1);
        check("fe_cnt", 32'(push_cnt - base), 32'd1);
        hold(1'b1, 200);

        // Break: line low for two frame times
        base = push_cnt;
        hold(1'b0, 1280);
        hold(1'b1, 200);
        check("brk_cnt", 32'(push_cnt - base), 32'd1);
        check("brk_word", 32'(last_word), 32'h005);

        // False start: four-tick glitch
        base = push_cnt;
        hold(1'b0, 16);
        check("glitch_start", 32'(rx_idle), 32'd0);
        hold(1'b1, 60);
        check("glitch_idle", 32'(rx_idle), 32'd1);
        hold(1'b1, 700);
        check("glitch_cnt", 32'(push_cnt - base), 32'd0);

        // Continuous enable: 16 clk per bit
        en_cont = 1'b1;
        repeat (4) @(negedge clk);
        base = push_cnt;
        send_frame(8'h3C, 8, -1, 1'b1, 1'b1, 16);
        check("cont_cnt", 32'(push_cnt - base), 32'd1);
        check("cont_word", 32'(last_word), 32'h1E0);
        en_cont = 1'b0;
        hold(1'b1, 20);

        // Reset during DATA discards the character
        base = push_cnt;
        hold(1'b0, 64);
        hold(1'b1, 100);
        wb_rst_i = 1'b1;
        @(negedge clk);
        check("mrst_push", 32'(fifo.rf_push), 32'd0);
        check("mrst_data", 32'(fifo.rf_data_in), 32'd0);
        check("mrst_idle", 32'(rx_idle), 32'd1);
        check("mrst_tmo", 32'(rx_timeout), 32'd0);
        wb_rst_i = 1'b0;
        hold(1'b1, 800);
        check("mrst_cnt", 32'(push_cnt - base), 32'd0);
        check("mrst_idle2", 32'(rx_idle), 32'd1);

        // Timeout: 8N1 threshold 640, then 8E2 threshold 768
        en_cont = 1'b1;
        lcr     = 8'h03;
        @(negedge clk);
        fifo.rf_count = 5'd3;
        repeat (639) @(posedge clk);
        @(negedge clk);
        check("tmo_639", 32'(rx_timeout), 32'd0);
        @(negedge clk);
        check("tmo_640", 32'(rx_timeout), 32'd1);
        repeat (400) @(negedge clk);
        check("tmo_sat", 32'(rx_timeout), 32'd1);
        fifo.rf_pop = 1'b1;
        @(negedge clk);
        check("tmo_pop", 32'(rx_timeout), 32'd0);
        fifo.rf_pop = 1'b0;
        lcr         = 8'h1F;
        repeat (767) @(posedge clk);
        @(negedge clk);
        check("tmo_767", 32'(rx_timeout), 32'd0);
        @(negedge clk);
        check("tmo_768", 32'(rx_timeout), 32'd1);
        fifo.rf_count = '0;
        @(negedge clk);
        check("tmo_empty", 32'(rx_timeout), 32'd0);

        check("no_consec_push", 32'(consec), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Serial receive front end of the UART. Synchronises the RX pad, detects and validates start bits, deserialises 5–8 data bits with optional parity on a 16× oversampling enable, and pushes one 11-bit word per character into the receive FIFO. It also generates the character-timeout indication from FIFO activity.

## Interface
Parameters:
- `FIFO_WIDTH`, 11: width of `rf_data_in`; layout is {data[7:0], break, parity_err, framing_err}.
- `FIFO_COUNTER_W`, 5: width of `rf_count`.
- `TOC_W`, 10: width of the timeout counter.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `wb_rst_i`  in  1  reset, synchronous and active-high.
- `enable`  in  1  one-`clk` pulse per 1/16 bit time, from the baud generator.
- `srx_pad_i`  in  1  asynchronous serial input; idle is high.
- `lcr`  in  8  line control: [1:0] char length − 5; [2] 2 stop bits; [3] parity enable; [4] even parity; [5] stick parity. [7:6] are ignored.
- `rf_count`  in  `FIFO_COUNTER_W`  current FIFO fill level.
- `rf_pop`  in  1  FIFO read strobe; reloads the timeout counter.
- `rf_push`  out  1  one-cycle push strobe to the FIFO.
- `rf_data_in`  out  `FIFO_WIDTH`  word to push; valid only while `rf_push` is high.
- `rx_idle`  out  1  high when the FSM is in IDLE.
- `rx_timeout`  out  1  character-timeout level.

## Operation
**Input synchroniser**
- Two flops on `srx_pad_i`; both reset to 1. The FSM uses only the synchronised value `srx_s` and its one-cycle-delayed copy.

**FSM**
- States: IDLE, START, DATA, PARITY, STOP, PUSH.
- `tick` is a 4-bit counter of `enable` pulses, cleared on every state entry. The line is sampled on the `enable` where `tick` == 7 (bit middle). After that sample, the FSM waits until `tick` == 15 and the next `enable` before leaving the bit.
- **IDLE:** a falling edge of `srx_s` (previous 1, current 0) moves to START. A line held low does not retrigger.
- **START:** at the mid-bit sample:
  - `srx_s` = 1 is a false start; return to IDLE with no push.
  - `srx_s` = 0: latch `lcr[5:0]` for the whole frame, then go to DATA.
- **DATA:** shift bits LSB first into `rshift`. Collect len = 5 + `lcr[1:0]` bits, then go to PARITY if parity is enabled, otherwise STOP. Unused upper bits of `rshift` are 0.
- **PARITY:** expected parity bit:
  - stick parity: `~lcr[4]`
  - even parity: `^data`
  - odd parity: `~^data`
  - A mismatch sets parity_err.
- **STOP:** only the first stop bit is checked; `lcr[2]` does not lengthen reception. A sample of 0 sets framing_err. Leave on the mid-bit sample, not at bit end, then go to PUSH.
- **PUSH:** for exactly one `clk`:
  - `rf_push` = 1
  - `rf_data_in` = {`rshift`, break, parity_err, framing_err}
  - Then go to IDLE.
- break = 1 when all data bits, the parity bit (if enabled) and the stop bit were all 0.
- The block pushes regardless of FIFO fullness; overrun detection is the FIFO's job.

**Timeout**
- `toc` counts `enable` pulses, saturating at its maximum.
- Reload to 0 when any of these holds: `rf_push`, `rf_pop`, `rf_count` == 0.
- frame_bits = 1 + len + parity_en + (`lcr[2]` ? 2 : 1).
- `rx_timeout` = (`toc` ≥ 64 × frame_bits) && (`rf_count` != 0). Max threshold is 768, which fits in 10 bits.

## Timing
- Reset values: state IDLE, `rf_push` 0, `rf_data_in` 0, `rx_idle` 1, `rx_timeout` 0, `toc` 0, synchroniser flops 1.
- Reset mid-frame: the partial character is discarded and nothing is pushed.
- A pad falling edge appears on `srx_s` 2 `clk` later; START entry follows 1 `clk` after that.
- `rf_push` is asserted in the `clk` after the `enable` that samples the stop bit. It is never asserted on two consecutive cycles.
- `rx_idle` deasserts in the cycle START is entered.
- `lcr` changes during a frame take effect at the next START confirmation.
- `enable` held continuously high: the FSM still advances one `tick` per `clk`.
- `rf_pop` and `rf_push` in the same cycle: `toc` reloads once.

## Test plan
- **8N1, byte 0xA5:** `lcr`=0x03, `enable` every 4 `clk` → one `rf_push` with `rf_data_in` = {0xA5, 3'b000}. `rx_idle` is high again after the push.
- **7E1 parity:** `lcr`=0x1A, send 0x35 with parity bit 1 → error bits 3'b010, data 0x35. Same frame with correct parity bit 0 → 3'b000.
- **Framing error:** 8N1, 0x5A with stop bit 0 → error bits 3'b001, data 0x5A. A line held low afterwards produces no further push until the line goes high and then low again.
- **Break:** line low for 2 frame times, 8N1 → one push of {0x00, 3'b101}. Only one push occurs.
- **False start:** 4-tick low glitch in IDLE → START, then IDLE, with no `rf_push`. `wb_rst_i` during DATA → no push and all outputs at reset values.
- **Timeout:** `rf_count`=3, no push or pop, 8N1 → `rx_timeout` rises after 640 `enable` pulses and falls the cycle after `rf_pop`.
